// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between bus masters and the arbiter.
// Latency: none, wires only.
// Backpressure: none; masters hold req until they are done with the bus.
interface rr_bus_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = (N > 2) ? $clog2(N) : 1
);
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    // Bus-master side: drives requests and arbitration mode.
    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    // Arbiter side: samples requests, drives the registered grant.
    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_valid,
        output gnt_id
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// N-requester bus arbiter, fixed-priority or round-robin, grant held until release.
// Latency: 1 cycle req->gnt, 1 cycle release->gnt low, one idle cycle between owners.
// Backpressure: owner keeps the bus while its req is high; others wait.
// Optional ARB_HOLD_LIMIT_EN: forced release after MAX_HOLD grant cycles.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    rr_bus_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t         state;
    logic [IDW-1:0] last;
    logic [N-1:0]   cand;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic           found;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0]     hold_cnt;
    logic           pre_vld;
    logic [IDW-1:0] pre_id;
    logic [N-1:0]   pre_mask;

    // Mask the preempted owner only when someone else is waiting.
    always_comb begin
        pre_mask = ONE << pre_id;
        cand     = bus.req;
        if (pre_vld && ((bus.req & ~pre_mask) != '0)) begin
            cand = bus.req & ~pre_mask;
        end
    end
`else
    // Without the hold limit every request is a candidate.
    always_comb begin
        cand = bus.req;
    end
`endif

    // Winner search: from index 0 in fixed mode, from last+1 in round robin.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.mode) begin
                idx = IDW'((int'(last) + 1 + k) % N);
            end else begin
                idx = IDW'(k);
            end
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Grant FSM with registered outputs; owner change always passes through IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= '0;
            last          <= IDW'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt      <= 8'd0;
            pre_vld       <= 1'b0;
            pre_id        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != '0) begin
                        state         <= BUSY;
                        bus.gnt       <= ONE << winner;
                        bus.gnt_valid <= 1'b1;
                        bus.gnt_id    <= winner;
                        last          <= winner;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt      <= 8'd1;
                        pre_vld       <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    if (!bus.req[bus.gnt_id]) begin
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt      <= 8'd0;
`endif
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    else if (hold_cnt >= 8'(MAX_HOLD)) begin
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                        hold_cnt      <= 8'd0;
                        pre_vld       <= 1'b1;
                        pre_id        <= bus.gnt_id;
                    end else begin
                        hold_cnt      <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized + directed bench for rr_bus_arbiter with a behavioural reference model.
// Latency: model predicts registered outputs one edge after inputs.
// Backpressure: n/a.
module tb_rr_bus_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    rr_bus_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_owner;   // -1 when nobody owns the bus
    int m_last;    // last granted index
    int m_id;      // reported gnt_id
    int m_held;    // cycles the current owner has held the bus
    int m_pre;     // index preempted by the hold limit, -1 if none

    function automatic int pick(input logic [N-1:0] r, input logic m, input int after);
        int order[$];
        order = {};
        for (int k = 0; k < N; k++) order.push_back(m ? (after + 1 + k) % N : k);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] r;
        if (!resetn) begin
            m_owner = -1; m_last = N - 1; m_id = 0; m_held = 0; m_pre = -1;
        end else if (m_owner < 0) begin
            r = bus.req;
            if (r != 0) begin
                if (m_pre >= 0 && ((r & ~(4'b1 << m_pre)) != 0)) r = r & ~(4'b1 << m_pre);
                m_owner = pick(r, bus.mode, m_last);
                m_last  = m_owner;
                m_id    = m_owner;
                m_held  = 1;
                m_pre   = -1;
            end
        end else if (!bus.req[m_owner]) begin
            m_owner = -1; m_held = 0;
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (m_held == MAX_HOLD) begin
                m_pre = m_owner; m_owner = -1; m_held = 0;
            end else begin
                m_held++;
            end
`else
            m_held++;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model on every falling edge after the first rising edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("model_gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("model_gnt_valid", 32'(bus.gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
            chk("model_gnt_id", 32'(bus.gnt_id), 32'(m_id));
        end
    end

    // Apply inputs at a falling edge, then wait for the next falling edge.
    task automatic cyc(input logic [N-1:0] r, input logic m);
        bus.req  = r;
        bus.mode = m;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] bit_k;
        checks = 0; failures = 0;
        resetn = 1'b0; bus.req = 4'b1111; bus.mode = 1'b0;

        // Reset held with all requests up
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_gnt", 32'(bus.gnt), 32'd0);
            chk("reset_valid", 32'(bus.gnt_valid), 32'd0);
            chk("reset_id", 32'(bus.gnt_id), 32'd0);
        end
        resetn = 1'b1;
        cyc(4'b1111, 1'b0);
        chk("post_reset_gnt", 32'(bus.gnt), 32'b0001);
        cyc(4'b0000, 1'b0);
        chk("release_gnt", 32'(bus.gnt), 32'd0);

        // Fixed priority
        cyc(4'b1100, 1'b0);
        chk("fp_gnt", 32'(bus.gnt), 32'b0100);
        chk("fp_id", 32'(bus.gnt_id), 32'd2);
        cyc(4'b1000, 1'b0);
        chk("fp_idle", 32'(bus.gnt), 32'd0);
        chk("fp_idle_id", 32'(bus.gnt_id), 32'd2);
        cyc(4'b1000, 1'b0);
        chk("fp_next", 32'(bus.gnt), 32'b1000);
        cyc(4'b0000, 1'b0);

        // Round robin, last owner was 3 so order is 0,1,2,3,0
        cyc(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            bit_k = 4'b0001 << (k % 4);
            chk("rr_gnt", 32'(bus.gnt), 32'(bit_k));
            chk("rr_id", 32'(bus.gnt_id), 32'(k % 4));
            cyc(4'b1111, 1'b1);
            cyc(4'b1111, 1'b1);
            chk("rr_hold", 32'(bus.gnt), 32'(bit_k));
            cyc(4'b1111 & ~bit_k, 1'b1);
            chk("rr_idle", 32'(bus.gnt), 32'd0);
            cyc(4'b1111, 1'b1);
        end
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);

        // Hold and ignore
        cyc(4'b0010, 1'b0);
        chk("hold_gnt", 32'(bus.gnt), 32'b0010);
        cyc(4'b0011, 1'b0);
        cyc(4'b0011, 1'b0);
        chk("hold_ignore", 32'(bus.gnt), 32'b0010);
        cyc(4'b0001, 1'b0);
        chk("hold_idle", 32'(bus.gnt), 32'd0);
        cyc(4'b0001, 1'b0);
        chk("hold_next", 32'(bus.gnt), 32'b0001);
        cyc(4'b0000, 1'b0);

        // Mode switch mid-grant
        cyc(4'b1000, 1'b0);
        chk("ms_gnt", 32'(bus.gnt), 32'b1000);
        cyc(4'b1000, 1'b1);
        chk("ms_busy", 32'(bus.gnt), 32'b1000);
        cyc(4'b0011, 1'b1);
        chk("ms_idle", 32'(bus.gnt), 32'd0);
        cyc(4'b1011, 1'b1);
        chk("ms_wrap", 32'(bus.gnt), 32'b0001);
        chk("ms_wrap_id", 32'(bus.gnt_id), 32'd0);
        cyc(4'b0000, 1'b0);

        // Hold limit (default build: owner keeps the bus past MAX_HOLD)
        cyc(4'b0011, 1'b0);
        chk("hl_gnt", 32'(bus.gnt), 32'b0001);
        for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b0);
        chk("hl_4th", 32'(bus.gnt), 32'b0001);
        cyc(4'b0011, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
        chk("hl_preempt", 32'(bus.gnt), 32'd0);
        cyc(4'b0011, 1'b0);
        chk("hl_masked", 32'(bus.gnt), 32'b0010);
`else
        chk("hl_nolimit", 32'(bus.gnt), 32'b0001);
        cyc(4'b0011, 1'b0);
        chk("hl_nolimit2", 32'(bus.gnt), 32'b0001);
`endif
        cyc(4'b0000, 1'b0);

        // Randomized traffic with occasional reset
        rq = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            if ($urandom_range(40) == 0) rq = '0;
            resetn = ($urandom_range(80) != 0);
            cyc(rq, 1'($urandom_range(1)));
        end
        resetn = 1'b1;
        cyc(4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
